// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
// Shared definitions for the EX/MEM pipeline register slice.
//   - DATA_W_DEF / RADDR_W_DEF : default widths of the data words and of the
//                                register-file write address.
//   - ex_mem_bundle_t          : packed EX->MEM payload at the default widths.
//                                The top builds its flat payload vector in the
//                                same field order, so the layout stays valid
//                                for non-default parameter values.
//   - gate_ctrl()              : masks a side-effecting control bit with the
//                                bundle valid bit.
package ex_mem_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RADDR_W_DEF = 3;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]  inst;
        logic [DATA_W_DEF-1:0]  res;
        logic [DATA_W_DEF-1:0]  store_data;
        logic                   wr_en;
        logic                   mem_store;
        logic                   wb_mem_select;
        logic [RADDR_W_DEF-1:0] write_addr;
    } ex_mem_bundle_t;

    localparam int BUNDLE_W_DEF = $bits(ex_mem_bundle_t);

    // A stale payload must never cause a register write or a memory store.
    function automatic logic gate_ctrl(input logic valid, input logic ctrl);
        return valid & ctrl;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Generic 2-entry skid register (main + skid) with a valid/ready handshake
// on both sides. in_ready is registered and equals "skid slot empty".
// Ordering is strictly FIFO. clr empties both entries on the next edge and
// takes priority over every other event; payload contents are kept.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   clr                      : synchronous clear of both valid bits
//   in_valid/in_ready/in_data: upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    logic [W-1:0] main_data_r;
    logic [W-1:0] skid_data_r;

    logic         main_valid_s;
    logic         skid_valid_s;
    logic [W-1:0] main_data_s;
    logic [W-1:0] skid_data_s;
    logic         accept_s;
    logic         main_free_s;

    assign accept_s    = in_valid & in_ready_r;
    // Main can take a new entry this edge if it is empty or being drained.
    assign main_free_s = ~main_valid_r | out_ready;

    // Next-state selection for both storage slots.
    always_comb begin
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        if (clr) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                // Older skid entry goes first; in_ready was low so no accept.
                main_data_s  = skid_data_r;
                main_valid_s = 1'b1;
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                main_data_s  = in_data;
                main_valid_s = 1'b1;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_data_s  = in_data;
                skid_valid_s = 1'b1;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid
// EX/MEM pipeline register with valid/ready handshake, flush and a 2-entry
// skid buffer (registered in_ready). 1-cycle latency, full throughput.
// Optional feature macro: EX_MEM_STALL_CNT_EN adds a 16-bit saturating
// stall_cycles output counting cycles with out_valid & !out_ready
// (cleared only by rst).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : EX-side handshake
//   flush               : kill every held bundle and the one offered now
//   inst, res, store_data_in, wr_en, mem_store_in, wb_mem_select_in,
//   write_addr          : EX-side payload
//   out_valid, out_ready: MEM-side handshake
//   *_out               : MEM-side payload; wr_en_out / mem_store_out are
//                         forced low whenever out_valid is low
//   stall_cycles        : (EX_MEM_STALL_CNT_EN only) stall cycle counter
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [DATA_W-1:0]  inst,
    input  logic [DATA_W-1:0]  res,
    input  logic [DATA_W-1:0]  store_data_in,
    input  logic               wr_en,
    input  logic               mem_store_in,
    input  logic               wb_mem_select_in,
    input  logic [RADDR_W-1:0] write_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  inst_out,
    output logic [DATA_W-1:0]  res_out,
    output logic [DATA_W-1:0]  store_data_out,
    output logic               wr_en_out,
    output logic               mem_store_out,
    output logic               wb_mem_select_out,
    output logic [RADDR_W-1:0] write_addr_out
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    // Same field order as ex_mem_bundle_t.
    localparam int PAY_W = 3 * DATA_W + 3 + RADDR_W;

    logic [PAY_W-1:0] in_bundle_s;
    logic [PAY_W-1:0] out_bundle_s;
    logic             out_valid_s;
    logic             held_wr_en_s;
    logic             held_mem_store_s;

    assign in_bundle_s = {inst, res, store_data_in, wr_en, mem_store_in,
                          wb_mem_select_in, write_addr};

    // A flush-cycle offer still sees in_ready, so the handshake completes
    // upstream; clr then discards it together with the held entries.
    pipe_skid_reg #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_bundle_s)
    );

    assign {inst_out, res_out, store_data_out, held_wr_en_s, held_mem_store_s,
            wb_mem_select_out, write_addr_out} = out_bundle_s;

    assign out_valid     = out_valid_s;
    assign wr_en_out     = gate_ctrl(out_valid_s, held_wr_en_s);
    assign mem_store_out = gate_ctrl(out_valid_s, held_mem_store_s);

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where MEM back-pressures a valid bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (out_valid_s && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: a table of directed vectors plus
// hand-written sequences for skid drain, asynchronous reset mid-stall and
// (with EX_MEM_STALL_CNT_EN) the stall counter.
module tb_ex_mem_skid;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] inst;
    logic [15:0] res;
    logic [15:0] store_data_in;
    logic        wr_en;
    logic        mem_store_in;
    logic        wb_mem_select_in;
    logic [2:0]  write_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] inst_out;
    logic [15:0] res_out;
    logic [15:0] store_data_out;
    logic        wr_en_out;
    logic        mem_store_out;
    logic        wb_mem_select_out;
    logic [2:0]  write_addr_out;
`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    ex_mem_skid dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .flush             (flush),
        .inst              (inst),
        .res               (res),
        .store_data_in     (store_data_in),
        .wr_en             (wr_en),
        .mem_store_in      (mem_store_in),
        .wb_mem_select_in  (wb_mem_select_in),
        .write_addr        (write_addr),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .inst_out          (inst_out),
        .res_out           (res_out),
        .store_data_out    (store_data_out),
        .wr_en_out         (wr_en_out),
        .mem_store_out     (mem_store_out),
        .wb_mem_select_out (wb_mem_select_out),
        .write_addr_out    (write_addr_out)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, ordy, fl;
        logic [15:0] res;
        logic [2:0]  wa;
        logic        we, ms;
        logic        ov, ir, chk;
        logic [15:0] res_o;
        logic [2:0]  wa_o;
        logic        we_o, ms_o;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic ordy, input logic fl,
        input logic [15:0] r, input logic [2:0] wa, input logic we, input logic ms,
        input logic ov, input logic ir, input logic chk,
        input logic [15:0] r_o, input logic [2:0] wa_o, input logic we_o, input logic ms_o);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.res = r; v.wa = wa; v.we = we; v.ms = ms;
        v.ov = ov; v.ir = ir; v.chk = chk; v.res_o = r_o; v.wa_o = wa_o;
        v.we_o = we_o; v.ms_o = ms_o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Side payload fields are derived from res so field swaps are visible.
    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [15:0] r, input logic [2:0] wa,
                         input logic we, input logic ms);
        in_valid         = iv;
        out_ready        = ordy;
        flush            = fl;
        res              = r;
        inst             = r ^ 16'h5A5A;
        store_data_in    = ~r;
        wb_mem_select_in = r[0];
        write_addr       = wa;
        wr_en            = we;
        mem_store_in     = ms;
    endtask

    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic [15:0] r, input logic [2:0] wa,
                        input logic we, input logic ms);
        @(negedge clk);
        drive(iv, ordy, fl, r, wa, we, ms);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_payload(input string tag, input logic [15:0] r);
        logic [15:0] inv_r;
        inv_r = ~r;
        chk({tag, "_res"},   res_out, r);
        chk({tag, "_inst"},  inst_out, r ^ 16'h5A5A);
        chk({tag, "_sdata"}, store_data_out, inv_r);
        chk({tag, "_wbsel"}, {15'd0, wb_mem_select_out}, {15'd0, r[0]});
    endtask

    vec_t vecs [19];

    initial begin
        vecs[0]  = mk(1'b1,1'b1,1'b0,16'h1111,3'd1,1'b1,1'b0, 1'b1,1'b1,1'b1,16'h1111,3'd1,1'b1,1'b0);
        vecs[1]  = mk(1'b1,1'b1,1'b0,16'h2222,3'd2,1'b0,1'b1, 1'b1,1'b1,1'b1,16'h2222,3'd2,1'b0,1'b1);
        vecs[2]  = mk(1'b1,1'b1,1'b0,16'h3333,3'd3,1'b1,1'b1, 1'b1,1'b1,1'b1,16'h3333,3'd3,1'b1,1'b1);
        vecs[3]  = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[4]  = mk(1'b1,1'b0,1'b0,16'h00AA,3'd4,1'b1,1'b0, 1'b1,1'b1,1'b1,16'h00AA,3'd4,1'b1,1'b0);
        vecs[5]  = mk(1'b1,1'b0,1'b0,16'h00BB,3'd5,1'b1,1'b1, 1'b1,1'b0,1'b1,16'h00AA,3'd4,1'b1,1'b0);
        vecs[6]  = mk(1'b1,1'b0,1'b0,16'h00CC,3'd6,1'b0,1'b0, 1'b1,1'b0,1'b1,16'h00AA,3'd4,1'b1,1'b0);
        vecs[7]  = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b1,1'b1,1'b1,16'h00BB,3'd5,1'b1,1'b1);
        vecs[8]  = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[9]  = mk(1'b1,1'b0,1'b0,16'h0D01,3'd1,1'b0,1'b0, 1'b1,1'b1,1'b1,16'h0D01,3'd1,1'b0,1'b0);
        vecs[10] = mk(1'b1,1'b1,1'b0,16'h0D02,3'd2,1'b1,1'b0, 1'b1,1'b1,1'b1,16'h0D02,3'd2,1'b1,1'b0);
        vecs[11] = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[12] = mk(1'b1,1'b0,1'b0,16'h0F01,3'd7,1'b1,1'b1, 1'b1,1'b1,1'b1,16'h0F01,3'd7,1'b1,1'b1);
        vecs[13] = mk(1'b1,1'b0,1'b1,16'h0F02,3'd6,1'b1,1'b1, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[14] = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[15] = mk(1'b1,1'b0,1'b0,16'h0E01,3'd1,1'b1,1'b0, 1'b1,1'b1,1'b1,16'h0E01,3'd1,1'b1,1'b0);
        vecs[16] = mk(1'b1,1'b0,1'b0,16'h0E02,3'd2,1'b0,1'b1, 1'b1,1'b0,1'b1,16'h0E01,3'd1,1'b1,1'b0);
        vecs[17] = mk(1'b0,1'b1,1'b1,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);
        vecs[18] = mk(1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0, 1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0);

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_in_ready",  {15'd0, in_ready},  16'h0001);
        chk("rst_res_out",   res_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].res, vecs[i].wa,
                  vecs[i].we, vecs[i].ms);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].ov});
            chk($sformatf("v%0d_in_ready", i),  {15'd0, in_ready},  {15'd0, vecs[i].ir});
            chk($sformatf("v%0d_wr_en_out", i), {15'd0, wr_en_out}, {15'd0, vecs[i].we_o});
            chk($sformatf("v%0d_mem_store_out", i), {15'd0, mem_store_out}, {15'd0, vecs[i].ms_o});
            if (vecs[i].chk) begin
                chk_payload($sformatf("v%0d", i), vecs[i].res_o);
                chk($sformatf("v%0d_write_addr_out", i), {13'd0, write_addr_out}, {13'd0, vecs[i].wa_o});
            end
        end

        // Main and skid full (addr 3 then 5), one-cycle out_ready pulse
        step(1'b1, 1'b0, 1'b0, 16'h0303, 3'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0505, 3'd5, 1'b0, 1'b1);
        chk("full_in_ready", {15'd0, in_ready}, 16'h0000);
        chk("full_wa", {13'd0, write_addr_out}, 16'h0003);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("pulse_wa", {13'd0, write_addr_out}, 16'h0005);
        chk("pulse_out_valid", {15'd0, out_valid}, 16'h0001);
        chk("pulse_in_ready", {15'd0, in_ready}, 16'h0001);
        chk("pulse_mem_store", {15'd0, mem_store_out}, 16'h0001);
        chk_payload("pulse", 16'h0505);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("hold_wa", {13'd0, write_addr_out}, 16'h0005);
        chk("hold_out_valid", {15'd0, out_valid}, 16'h0001);

        // Asynchronous reset mid-stall with both entries full
        step(1'b1, 1'b0, 1'b0, 16'h0606, 3'd6, 1'b1, 1'b1);
        chk("stall_in_ready", {15'd0, in_ready}, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("arst_in_ready",  {15'd0, in_ready},  16'h0001);
        chk("arst_res_out",   res_out, 16'h0000);
        chk("arst_inst_out",  inst_out, 16'h0000);
        chk("arst_wa",        {13'd0, write_addr_out}, 16'h0000);
        chk("arst_wr_en",     {15'd0, wr_en_out}, 16'h0000);
        chk("arst_mem_store", {15'd0, mem_store_out}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

`ifdef EX_MEM_STALL_CNT_EN
        chk("cnt_reset", stall_cycles, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0707, 3'd7, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        end
        chk("cnt_10", stall_cycles, 16'h000A);
        @(negedge clk);
        dut.stall_cnt_r = 16'hFFFE;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        end
        chk("cnt_sat", stall_cycles, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0);
        chk("cnt_after_flush", stall_cycles, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Parametrised successor to the EX/MEM pipeline register: carries EX results, store data and writeback control into MEM with a valid/ready handshake.
- Adds stall back-pressure, flush and a 2-entry skid buffer so that in_ready is a registered signal.
- Sits between the ALU/EX stage and the data-memory stage.
- Latency is 1 cycle when unstalled, with full throughput.

Parameters:
- DATA_W, 16, width of inst, res and store_data.
- RADDR_W, 3, register-file write address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  block can accept; registered.
- flush  in  1  kill all held bundles (branch/exception).
- inst  in  DATA_W  instruction word.
- res  in  DATA_W  ALU result or address.
- store_data_in  in  DATA_W  data for store.
- wr_en  in  1  register-file write enable.
- mem_store_in  in  1  memory store request.
- wb_mem_select_in  in  1  writeback source select (1 = memory).
- write_addr  in  RADDR_W  destination register.
- out_valid  out  1  MEM-facing bundle valid.
- out_ready  in  1  MEM accepts bundle.
- inst_out, res_out, store_data_out  out  DATA_W each  held payload.
- wr_en_out, mem_store_out, wb_mem_select_out  out  1 each  held control.
- write_addr_out  out  RADDR_W  held destination.

Behaviour:
- Storage: main register (drives outputs) and skid register, each with a valid bit.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - Payload must be stable while out_valid & !out_ready.
- in_ready = !skid_valid, registered. Reset value is 1.
- Capture rules:
  - Accept while main empty or draining → data goes to main (or main loads from skid first, keeping order).
  - Accept while main full and not draining → data goes to skid; in_ready drops the next cycle.
  - Drain with skid full → skid moves to main, skid empties, in_ready rises the next cycle.
  - Ordering is strictly FIFO; no bundle is duplicated or dropped except by flush.
- Safety gating: wr_en_out and mem_store_out are forced 0 whenever out_valid = 0, regardless of held payload.
- Flush:
  - Synchronous. Clears both valid bits on the next edge.
  - A bundle offered in the same cycle is consumed (handshake counts) and discarded.
  - Flush has priority over every other event.
  - Payload registers need not clear on flush.
- Reset (asynchronous, any time, including mid-stall):
  - All outputs 0; out_valid 0; in_ready 1; skid empty.
- Simultaneous accept and drain with main full and skid empty → main reloads from input; skid stays empty.
- No arithmetic in the datapath; widths pass through unchanged.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (16 bits).
  - Increments each cycle with out_valid & !out_ready; saturates at 0xFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package ex_mem_pkg:
  - Packed payload typedef ex_mem_bundle_t (inst, res, store_data, wr_en, mem_store, wb_mem_select, write_addr).
  - Default width constants matching the parameters.
- One sub-module, pipe_skid_reg: a generic 2-entry skid register over a payload width. ex_mem_skid instantiates it and adds flush and control gating.

Test Plan:
- Reset mid-stall → all outputs 0, out_valid 0, in_ready 1 immediately (asynchronous, before the next edge).
- Stream 0x1111, 0x2222, 0x3333 with out_ready = 1 → res_out shows each value one cycle after acceptance; out_valid stays high; in_ready stays 1.
- out_ready = 0 while sending A = 0x00AA then B = 0x00BB → in_ready drops after B is stored in skid. Raise out_ready → A then B drain in order; in_ready returns to 1.
- Flush asserted with a bundle held (wr_en = 1, mem_store = 1) and a new bundle offered in the same cycle → next cycle out_valid = 0, wr_en_out = 0, mem_store_out = 0; neither bundle ever appears on the output.
- Main and skid full (write_addr 3 then 5), with out_ready pulsed for one cycle → write_addr_out changes 3→5; skid empties; in_ready rises the next cycle.
- With EX_MEM_STALL_CNT_EN defined: hold out_valid & !out_ready for 10 cycles → stall_cycles = 10. Force the counter to 0xFFFE and stall 5 cycles → stall_cycles = 0xFFFF (saturated).
